// File: rtl/uart_tx_arbiter_if.sv
// Bundle between two UART requesters, the arbiter and the UART transmitter.
// Handshake: reqN is a level request held until doneN is seen; grantN marks
// ownership of the transmitter; tx_start is a one-cycle launch pulse and
// tx_active is high while the transmitter is sending.
interface uart_tx_arbiter_if;
  logic        req0;
  logic        req1;
  logic [63:0] data0;
  logic [63:0] data1;
  logic        grant0;
  logic        grant1;
  logic        done0;
  logic        done1;
  logic        timeout_err;
  logic [63:0] tx_array;
  logic        tx_start;
  logic        tx_active;

  modport master (
    output req0, req1, data0, data1, tx_active,
    input  grant0, grant1, done0, done1, timeout_err, tx_array, tx_start
  );

  modport slave (
    input  req0, req1, data0, data1, tx_active,
    output grant0, grant1, done0, done1, timeout_err, tx_array, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of two requesters an 8-byte UART transfer.
// Optional watchdog on the transmitter handshake: define UART_TX_ARB_TIMEOUT_EN.
// state_o exposes the FSM state for debug.
module uart_tx_arbiter #(
  parameter int ACT_TIMEOUT  = 16,
  parameter int BUSY_TIMEOUT = 69504
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ACT = 3'd2,
    BUSY     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        run_ok;
  logic        pick;
  logic        finish;
  logic        winner_q, winner_d;   // 0: requester 0, 1: requester 1
  logic        last_q, last_d;       // requester served most recently
  logic        grant0_q, grant0_d;
  logic        grant1_q, grant1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        tx_start_q, tx_start_d;
  logic [63:0] tx_array_q, tx_array_d;
  logic        act_expire;
  logic        busy_expire;

  // Reset release is synchronised so requests are only sampled once it settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run_ok = rst_sync_q[1];

  // With both requesting the one not served last wins; otherwise the single requester.
  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_array_q <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      tx_start_q <= tx_start_d;
      tx_array_q <= tx_array_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    grant0_d   = grant0_q;
    grant1_d   = grant1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    tx_start_d = 1'b0;
    tx_array_d = tx_array_q;
    finish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_ok && (bus.req0 || bus.req1)) begin
          winner_d   = pick;
          tx_array_d = pick ? bus.data1 : bus.data0;
          grant0_d   = ~pick;
          grant1_d   = pick;
          state_d    = LAUNCH;
        end
      end
      // First LAUNCH cycle arms the pulse, second cycle carries it.
      LAUNCH: begin
        if (!tx_start_q) tx_start_d = 1'b1;
        else             state_d    = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (bus.tx_active) state_d = BUSY;
        else if (act_expire) finish = 1'b1;
      end
      BUSY: begin
        if (!bus.tx_active || busy_expire) finish = 1'b1;
      end
      DONE: begin
        last_d  = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d  = DONE;
      done0_d  = ~winner_q;
      done1_d  = winner_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_MAX = (ACT_TIMEOUT > BUSY_TIMEOUT) ? ACT_TIMEOUT : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;

  // The tx_start cycle counts toward the activity window, so the done pulse
  // lands ACT_TIMEOUT cycles after tx_start.
  assign act_expire  = (cnt_q == CNT_W'(ACT_TIMEOUT - 2));
  assign busy_expire = (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

  // Per-state cycle counter, cleared whenever a state is entered.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    tout_d = (state_q == WAIT_ACT && !bus.tx_active && act_expire) ||
             (state_q == BUSY && bus.tx_active && busy_expire);
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign bus.timeout_err = tout_q;
`else
  assign act_expire      = 1'b0;
  assign busy_expire     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant0   = grant0_q;
  assign bus.grant1   = grant1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_array = tx_array_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short-bit-time transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int BIT_CLKS = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] state_o;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected serial bytes
  logic [7:0] exp_q[$];
  logic       bits_q[$];

  // Transmitter model
  logic model_en = 1'b1;
  logic model_active = 1'b0;
  logic manual_active = 1'b0;
  logic tx_line = 1'b1;
  assign bus.tx_active = model_active | manual_active;

  initial begin
    logic [63:0] frame;
    forever begin
      @(negedge clk);
      if (model_en && bus.tx_start) begin
        frame = bus.tx_array;
        @(negedge clk);
        model_active = 1'b1;
        for (int k = 0; k < 8; k++) begin
          for (int b = 0; b < 10; b++) begin
            tx_line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : frame[8*k + b - 1];
            bits_q.push_back(tx_line);
            repeat (BIT_CLKS) @(negedge clk);
          end
        end
        tx_line = 1'b1;
        model_active = 1'b0;
      end
    end
  end

  // Event monitors
  int start_cnt = 0;
  int both_cnt  = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;
  always @(negedge clk) begin
    if (bus.tx_start) start_cnt++;
    if (bus.grant0 && bus.grant1) both_cnt++;
    if (bus.done0) done0_cnt++;
    if (bus.done1) done1_cnt++;
  end

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    manual_active = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bits_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) seen = 1'b1;
    end
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.grant0 || bus.grant1) seen = 1'b1;
    end
  endtask

  task automatic pop_frame(output logic [9:0] f);
    f = 'x;
    if (bits_q.size() >= 10)
      for (int i = 0; i < 10; i++) f[i] = bits_q.pop_front();
  endtask

  task automatic push_bytes(input logic [63:0] d);
    for (int k = 0; k < 8; k++) exp_q.push_back(d[8*k +: 8]);
  endtask

  // Tests
  task automatic test_reset();
    bit seen;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 64'h0; bus.data1 = 64'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.grant0, bus.grant1, bus.done0, bus.done1, bus.tx_start, bus.timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
        {bus.grant0, bus.grant1, bus.done0, bus.done1, bus.tx_start, bus.timeout_err});
    end
    n_checks++;
    if (bus.tx_array !== 64'h0) begin
      n_fail++; $display("FAIL reset_array: got %h expected 0", bus.tx_array);
    end
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    bus.req0 = 1'b1;
    bus.data0 = 64'hA5A5_0000_1111_2222;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.grant0 !== 1'b0) begin n_fail++; $display("FAIL reset_sync_early: got %b expected 0", bus.grant0); end
    wait_grant(seen);
    n_checks++;
    if (!(seen && bus.grant0)) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 1", bus.grant0); end
    wait_done(seen);
    bus.req0 = 1'b0;
    n_checks++;
    if (!(seen && bus.done0)) begin n_fail++; $display("FAIL reset_first_done: got %b expected 1", bus.done0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit seen;
    int s0, d0;
    logic [9:0] f;
    logic [7:0] eb;
    apply_reset();
    model_en = 1'b1;
    push_bytes(64'h0807060504030201);
    s0 = start_cnt; d0 = done0_cnt;
    bus.req0 = 1'b1;
    bus.data0 = 64'h0807060504030201;
    @(negedge clk);
    n_checks++;
    if ({bus.grant0, bus.grant1, bus.tx_start} !== 3'b100) begin
      n_fail++; $display("FAIL single_grant: got %b expected 100", {bus.grant0, bus.grant1, bus.tx_start});
    end
    n_checks++;
    if (bus.tx_array !== 64'h0807060504030201) begin
      n_fail++; $display("FAIL single_array: got %h expected 0807060504030201", bus.tx_array);
    end
    @(negedge clk);
    n_checks++;
    if (bus.tx_start !== 1'b1 || state_o !== 3'd1) begin
      n_fail++; $display("FAIL single_start: got %b/%0d expected 1/1", bus.tx_start, state_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_len: got %b expected 0", bus.tx_start); end
    wait_done(seen);
    n_checks++;
    if ({seen, bus.done0, bus.done1, bus.timeout_err, bus.grant0} !== 5'b11000) begin
      n_fail++; $display("FAIL single_done: got %b expected 11000",
        {seen, bus.done0, bus.done1, bus.timeout_err, bus.grant0});
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0 || bus.done0 !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got %0d/%b expected 0/0", state_o, bus.done0);
    end
    n_checks++;
    if (start_cnt - s0 != 1 || done0_cnt - d0 != 1) begin
      n_fail++; $display("FAIL single_pulses: got %0d/%0d expected 1/1", start_cnt - s0, done0_cnt - d0);
    end
    for (int k = 0; k < 8; k++) begin
      pop_frame(f);
      eb = exp_q.pop_front();
      n_checks++;
      if (f !== {1'b1, eb, 1'b0}) begin
        n_fail++; $display("FAIL single_byte%0d: got %b expected %b", k, f, {1'b1, eb, 1'b0});
      end
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int b0, s0;
    logic exp_who[4];
    logic who;
    apply_reset();
    model_en = 1'b1;
    exp_who = '{1'b0, 1'b1, 1'b0, 1'b1};
    b0 = both_cnt; s0 = start_cnt;
    bus.data0 = 64'h1111_1111_AAAA_AAAA;
    bus.data1 = 64'h2222_2222_BBBB_BBBB;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(seen);
      who = bus.grant1;
      n_checks++;
      if (!seen || who !== exp_who[i]) begin
        n_fail++; $display("FAIL rr_order%0d: got %b expected %b", i, who, exp_who[i]);
      end
      n_checks++;
      if (bus.tx_array !== (exp_who[i] ? 64'h2222_2222_BBBB_BBBB : 64'h1111_1111_AAAA_AAAA)) begin
        n_fail++; $display("FAIL rr_array%0d: got %h", i, bus.tx_array);
      end
      wait_done(seen);
      n_checks++;
      if (!seen || {bus.done1, bus.done0} !== (exp_who[i] ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_done%0d: got %b%b", i, bus.done1, bus.done0);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (both_cnt != b0 || start_cnt - s0 != 4) begin
      n_fail++; $display("FAIL rr_excl: got both=%0d starts=%0d expected 0/4", both_cnt - b0, start_cnt - s0);
    end
    bits_q.delete();
  endtask

  task automatic test_data_hold();
    bit seen;
    logic [9:0] f;
    logic [7:0] eb;
    apply_reset();
    model_en = 1'b1;
    push_bytes(64'h1122334455667788);
    bus.data0 = 64'h1122334455667788;
    bus.req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (state_o == 3'd3) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL hold_busy: got %0d expected 3", state_o); end
    bus.data0 = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.tx_array !== 64'h1122334455667788) begin
      n_fail++; $display("FAIL hold_array: got %h expected 1122334455667788", bus.tx_array);
    end
    wait_done(seen);
    bus.req0 = 1'b0;
    n_checks++;
    if (!(seen && bus.done0)) begin n_fail++; $display("FAIL hold_done: got %b expected 1", bus.done0); end
    for (int k = 0; k < 8; k++) begin
      pop_frame(f);
      eb = exp_q.pop_front();
      n_checks++;
      if (f !== {1'b1, eb, 1'b0}) begin
        n_fail++; $display("FAIL hold_byte%0d: got %b expected %b", k, f, {1'b1, eb, 1'b0});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int dsum;
    logic [9:0] f;
    logic [7:0] eb;
    apply_reset();
    model_en = 1'b0;
    bus.data0 = 64'hDEAD_BEEF_0BAD_F00D;
    bus.req0 = 1'b1;
    wait_grant(seen);
    repeat (3) @(negedge clk);
    manual_active = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL rmid_busy: got %0d expected 3", state_o); end
    repeat (100) @(negedge clk);
    dsum = done0_cnt + done1_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.grant0, bus.grant1, bus.done0, bus.done1, bus.tx_start, bus.timeout_err} !== 6'b0 ||
        bus.tx_array !== 64'h0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL rmid_async: got %b %h %0d expected 000000 0 0",
        {bus.grant0, bus.grant1, bus.done0, bus.done1, bus.tx_start, bus.timeout_err}, bus.tx_array, state_o);
    end
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    manual_active = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done0_cnt + done1_cnt != dsum || state_o !== 3'd0 || bus.grant0 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_quiet: got dones=%0d state=%0d expected 0/0", done0_cnt + done1_cnt - dsum, state_o);
    end
    model_en = 1'b1;
    bits_q.delete();
    push_bytes(64'hCAFE_0123_4567_89AB);
    bus.data1 = 64'hCAFE_0123_4567_89AB;
    bus.req1 = 1'b1;
    wait_grant(seen);
    n_checks++;
    if (!seen || {bus.grant1, bus.grant0} !== 2'b10) begin
      n_fail++; $display("FAIL rmid_regrant: got %b%b expected 10", bus.grant1, bus.grant0);
    end
    wait_done(seen);
    bus.req1 = 1'b0;
    n_checks++;
    if (!seen || {bus.done1, bus.timeout_err} !== 2'b10) begin
      n_fail++; $display("FAIL rmid_done: got %b%b expected 10", bus.done1, bus.timeout_err);
    end
    for (int k = 0; k < 8; k++) begin
      pop_frame(f);
      eb = exp_q.pop_front();
      n_checks++;
      if (f !== {1'b1, eb, 1'b0}) begin
        n_fail++; $display("FAIL rmid_byte%0d: got %b expected %b", k, f, {1'b1, eb, 1'b0});
      end
    end
    @(negedge clk);
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    int k;
    apply_reset();
    model_en = 1'b0;
    bus.data0 = 64'h0807060504030201;
    bus.req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_start) seen = 1'b1;
    end
    k = 0;
    for (int i = 0; i < 40 && seen; i++) begin
      @(negedge clk);
      k++;
      if (bus.done0) break;
    end
    n_checks++;
    if (!seen || k != 16 || {bus.done0, bus.timeout_err} !== 2'b11) begin
      n_fail++; $display("FAIL timeout_done: got k=%0d done/err=%b%b expected 16/11", k, bus.done0, bus.timeout_err);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0 || bus.timeout_err !== 1'b0 || bus.grant0 !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: got %0d/%b expected 0/0", state_o, bus.timeout_err);
    end
    model_en = 1'b1;
  endtask
`else
  task automatic test_timeout();
    int bad;
    apply_reset();
    model_en = 1'b0;
    bus.data0 = 64'h0807060504030201;
    bus.req0 = 1'b1;
    repeat (4) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.grant0 !== 1'b1 || bus.timeout_err !== 1'b0 || bus.done0 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL no_timeout_hold: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (state_o !== 3'd2) begin n_fail++; $display("FAIL no_timeout_state: got %0d expected 2", state_o); end
    apply_reset();
    model_en = 1'b1;
  endtask
`endif

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = 64'h0;
    bus.data1 = 64'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_data_hold();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
